// File: rtl/ex_lsu.sv
// rtl/ex_lsu.sv - EX-stage load/store unit with single-outstanding memory handshake
// Computes the effective address, shifts store data into lanes, extends load data, and raises precise faults.
module ex_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_load,
    input  logic [2:0]          req_funct3,
    input  logic [4:0]          req_rd,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic [11:0]         req_imm,
    output logic                busy,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic                mem_read_en,
    output logic                mem_write_en,
    input  logic [XLEN-1:0]     mem_data_in,
    input  logic                mem_read_ready,
    input  logic                mem_write_ready,
    output logic                wb_rd_wait,
    output logic [4:0]          rd_out,
    output logic                rd_en,
    output logic [XLEN-1:0]     rd_data,
    output logic                exc_valid,
    output logic [3:0]          exc_cause,
    output logic [XLEN-1:0]     exc_tval
);

    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [1:0]      ld_size;
    logic            ld_uns;

    logic [XLEN-1:0] ea;
    logic [1:0]      size;
    logic [LB-1:0]   lane;
    logic            illegal;
    logic            misaligned;
    logic [NB-1:0]   base_strb;
    logic [XLEN-1:0] byte_mask;
    logic [XLEN-1:0] store_data;
    logic [NB-1:0]   store_strb;
    logic [XLEN-1:0] load_shifted;
    logic [XLEN-1:0] load_ext;
    logic            fill;

    // Immediate is sign-extended for every op, including the unsigned loads.
    assign ea   = rs1_data + {{(XLEN-12){req_imm[11]}}, req_imm};
    assign size = req_funct3[1:0];
    assign lane = ea[LB-1:0];

    always_comb begin
        illegal = 1'b0;
        if (req_funct3 == 3'b111)
            illegal = 1'b1;
        if (!req_load && req_funct3[2])
            illegal = 1'b1;
        if (XLEN == 32 && (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110))
            illegal = 1'b1;
    end

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b01:   misaligned = ea[0];
            2'b10:   misaligned = (ea[1:0] != 2'b00);
            2'b11:   misaligned = (ea[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        base_strb = '0;
        byte_mask = '0;
        for (int i = 0; i < NB; i++) begin
            base_strb[i]       = (i < (1 << size));
            byte_mask[8*i +: 8] = {8{base_strb[i]}};
        end
    end

    // Bytes above the access size are zeroed so unused lanes never carry stale data.
    assign store_data = (rs2_data & byte_mask) << {lane, 3'b000};
    assign store_strb = base_strb << lane;

    assign load_shifted = mem_data_in >> {mem_addr[LB-1:0], 3'b000};

    always_comb begin
        fill = 1'b0;
        case (ld_size)
            2'b00:   fill = load_shifted[7];
            2'b01:   fill = load_shifted[15];
            default: fill = load_shifted[31];
        endcase
        fill     = fill & ~ld_uns;
        load_ext = load_shifted;
        for (int i = 8; i < XLEN; i++) begin
            if (i >= (8 << ld_size))
                load_ext[i] = fill;
        end
    end

    assign busy       = (state == S_IDLE && req_valid) || state == S_READ || state == S_WRITE;
    assign wb_rd_wait = (state == S_READ) ||
                        (state == S_IDLE && req_valid && req_load && !illegal && !misaligned);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            ld_size      <= 2'b00;
            ld_uns       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            rd_out       <= 5'd0;
            rd_en        <= 1'b0;
            rd_data      <= '0;
            exc_valid    <= 1'b0;
            exc_cause    <= 4'd0;
            exc_tval     <= '0;
        end else begin
            rd_en     <= 1'b0;
            exc_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            state     <= S_ERR;
                            exc_valid <= 1'b1;
                            exc_cause <= 4'd2;
                            exc_tval  <= '0;
                            rd_out    <= 5'd0;
                        end else if (misaligned) begin
                            state     <= S_ERR;
                            exc_valid <= 1'b1;
                            exc_cause <= req_load ? 4'd4 : 4'd6;
                            exc_tval  <= ea;
                            rd_out    <= 5'd0;
                        end else begin
                            mem_addr <= ea;
                            wait_cnt <= '0;
                            ld_size  <= size;
                            ld_uns   <= req_funct3[2];
                            if (req_load) begin
                                state       <= S_READ;
                                mem_read_en <= 1'b1;
                                mem_wdata   <= '0;
                                mem_wstrb   <= '0;
                                rd_out      <= req_rd;
                            end else begin
                                state        <= S_WRITE;
                                mem_write_en <= 1'b1;
                                mem_wdata    <= store_data;
                                mem_wstrb    <= store_strb;
                                rd_out       <= 5'd0;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (mem_read_ready) begin
                        state       <= S_DONE;
                        mem_read_en <= 1'b0;
                        rd_data     <= load_ext;
                        rd_en       <= (rd_out != 5'd0);
                    end else if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
                        state       <= S_ERR;
                        mem_read_en <= 1'b0;
                        exc_valid   <= 1'b1;
                        exc_cause   <= 4'd5;
                        exc_tval    <= mem_addr;
                        rd_out      <= 5'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_write_ready) begin
                        state        <= S_DONE;
                        mem_write_en <= 1'b0;
                    end else if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
                        state        <= S_ERR;
                        mem_write_en <= 1'b0;
                        exc_valid    <= 1'b1;
                        exc_cause    <= 4'd7;
                        exc_tval     <= mem_addr;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_lsu.sv
// tb/tb_ex_lsu.sv - directed bench for ex_lsu at XLEN=32 (TIMEOUT=4) and XLEN=64 (no timeout)
module tb_ex_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        a_req_valid, a_req_load, a_busy, a_ren, a_wen, a_rrdy, a_wrdy, a_wait, a_rd_en, a_exc;
    logic [2:0]  a_funct3;
    logic [4:0]  a_rd, a_rd_out;
    logic [11:0] a_imm;
    logic [31:0] a_rs1, a_rs2, a_addr, a_wdata, a_din, a_rd_data, a_tval;
    logic [3:0]  a_wstrb, a_cause;

    logic        b_req_valid, b_req_load, b_busy, b_ren, b_wen, b_rrdy, b_wrdy, b_wait, b_rd_en, b_exc;
    logic [2:0]  b_funct3;
    logic [4:0]  b_rd, b_rd_out;
    logic [11:0] b_imm;
    logic [63:0] b_rs1, b_rs2, b_addr, b_wdata, b_din, b_rd_data, b_tval;
    logic [7:0]  b_wstrb;
    logic [3:0]  b_cause;

    ex_lsu #(.XLEN(32), .TIMEOUT(4)) u32 (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_load(a_req_load), .req_funct3(a_funct3),
        .req_rd(a_rd), .rs1_data(a_rs1), .rs2_data(a_rs2), .req_imm(a_imm), .busy(a_busy),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wstrb(a_wstrb), .mem_read_en(a_ren),
        .mem_write_en(a_wen), .mem_data_in(a_din), .mem_read_ready(a_rrdy), .mem_write_ready(a_wrdy),
        .wb_rd_wait(a_wait), .rd_out(a_rd_out), .rd_en(a_rd_en), .rd_data(a_rd_data),
        .exc_valid(a_exc), .exc_cause(a_cause), .exc_tval(a_tval)
    );

    ex_lsu #(.XLEN(64), .TIMEOUT(0)) u64 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_load(b_req_load), .req_funct3(b_funct3),
        .req_rd(b_rd), .rs1_data(b_rs1), .rs2_data(b_rs2), .req_imm(b_imm), .busy(b_busy),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wstrb(b_wstrb), .mem_read_en(b_ren),
        .mem_write_en(b_wen), .mem_data_in(b_din), .mem_read_ready(b_rrdy), .mem_write_ready(b_wrdy),
        .wb_rd_wait(b_wait), .rd_out(b_rd_out), .rd_en(b_rd_en), .rd_data(b_rd_data),
        .exc_valid(b_exc), .exc_cause(b_cause), .exc_tval(b_tval)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_issue(input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [11:0] imm);
        a_req_load = ld; a_funct3 = f3; a_rd = rd; a_rs1 = rs1; a_rs2 = rs2; a_imm = imm;
        a_req_valid = 1'b1;
        #1;
    endtask

    task automatic b_issue(input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [63:0] rs1, input logic [63:0] rs2, input logic [11:0] imm);
        b_req_load = ld; b_funct3 = f3; b_rd = rd; b_rs1 = rs1; b_rs2 = rs2; b_imm = imm;
        b_req_valid = 1'b1;
        #1;
    endtask

    task automatic a_idle();
        a_req_valid = 1'b0; a_rrdy = 1'b0; a_wrdy = 1'b0;
        #1;
    endtask

    task automatic b_idle();
        b_req_valid = 1'b0; b_rrdy = 1'b0; b_wrdy = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        vectors++; if (a_ren !== 1'b0) begin miscompares++; $display("FAIL rst_ren got %h exp 0", a_ren); end
        vectors++; if (a_wen !== 1'b0) begin miscompares++; $display("FAIL rst_wen got %h exp 0", a_wen); end
        vectors++; if (a_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h exp 0", a_addr); end
        vectors++; if (a_rd_en !== 1'b0 || a_exc !== 1'b0) begin miscompares++; $display("FAIL rst_pulses got rd_en=%h exc=%h exp 0", a_rd_en, a_exc); end
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %h exp 0", a_busy); end
        vectors++; if (b_rd_data !== 64'h0) begin miscompares++; $display("FAIL rst_rd_data64 got %h exp 0", b_rd_data); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lb();
        a_issue(1'b1, 3'b000, 5'd5, 32'h1000, 32'h0, 12'h003);
        vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("FAIL lb_busy got %h exp 1", a_busy); end
        vectors++; if (a_wait !== 1'b1) begin miscompares++; $display("FAIL lb_wait got %h exp 1", a_wait); end
        step();
        vectors++; if (a_ren !== 1'b1) begin miscompares++; $display("FAIL lb_ren got %h exp 1", a_ren); end
        vectors++; if (a_addr !== 32'h1003) begin miscompares++; $display("FAIL lb_addr got %h exp 00001003", a_addr); end
        vectors++; if (a_wstrb !== 4'h0) begin miscompares++; $display("FAIL lb_wstrb got %h exp 0", a_wstrb); end
        a_din = 32'h8012_3456; a_rrdy = 1'b1;
        step();
        vectors++; if (a_rd_en !== 1'b1) begin miscompares++; $display("FAIL lb_rd_en got %h exp 1", a_rd_en); end
        vectors++; if (a_rd_data !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_data got %h exp ffffff80", a_rd_data); end
        vectors++; if (a_rd_out !== 5'd5) begin miscompares++; $display("FAIL lb_rd_out got %h exp 05", a_rd_out); end
        vectors++; if (a_ren !== 1'b0 || a_busy !== 1'b0) begin miscompares++; $display("FAIL lb_done got ren=%h busy=%h exp 0", a_ren, a_busy); end
        a_idle();
        step();
        vectors++; if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL lb_rd_en_pulse got %h exp 0", a_rd_en); end
        vectors++; if (a_rd_data !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_data_hold got %h exp ffffff80", a_rd_data); end
    endtask

    task automatic test_lhu();
        a_issue(1'b1, 3'b101, 5'd7, 32'h2000, 32'h0, 12'hFFE);
        step();
        vectors++; if (a_addr !== 32'h1FFE) begin miscompares++; $display("FAIL lhu_addr got %h exp 00001ffe", a_addr); end
        a_din = 32'h8001_1234; a_rrdy = 1'b1;
        step();
        vectors++; if (a_rd_data !== 32'h0000_8001) begin miscompares++; $display("FAIL lhu_data got %h exp 00008001", a_rd_data); end
        vectors++; if (a_rd_en !== 1'b1) begin miscompares++; $display("FAIL lhu_rd_en got %h exp 1", a_rd_en); end
        a_idle();
        step();
    endtask

    task automatic test_store_lanes();
        a_issue(1'b0, 3'b000, 5'd0, 32'h100, 32'h1234_5678, 12'h002);
        vectors++; if (a_wait !== 1'b0) begin miscompares++; $display("FAIL sb_wait got %h exp 0", a_wait); end
        step();
        vectors++; if (a_wen !== 1'b1) begin miscompares++; $display("FAIL sb_wen got %h exp 1", a_wen); end
        vectors++; if (a_wdata !== 32'h0078_0000) begin miscompares++; $display("FAIL sb_wdata got %h exp 00780000", a_wdata); end
        vectors++; if (a_wstrb !== 4'b0100) begin miscompares++; $display("FAIL sb_wstrb got %h exp 4", a_wstrb); end
        vectors++; if (a_addr !== 32'h102) begin miscompares++; $display("FAIL sb_addr got %h exp 00000102", a_addr); end
        step();
        vectors++; if (a_wen !== 1'b1 || a_busy !== 1'b1) begin miscompares++; $display("FAIL sb_hold got wen=%h busy=%h exp 1", a_wen, a_busy); end
        a_wrdy = 1'b1;
        step();
        vectors++; if (a_wen !== 1'b0 || a_rd_en !== 1'b0) begin miscompares++; $display("FAIL sb_done got wen=%h rd_en=%h exp 0", a_wen, a_rd_en); end
        vectors++; if (a_rd_out !== 5'd0) begin miscompares++; $display("FAIL sb_rd_out got %h exp 0", a_rd_out); end
        a_idle();
        step();
        a_issue(1'b0, 3'b001, 5'd0, 32'h400, 32'hAABB_CCDD, 12'h002);
        step();
        vectors++; if (a_wdata !== 32'hCCDD_0000) begin miscompares++; $display("FAIL sh_wdata got %h exp ccdd0000", a_wdata); end
        vectors++; if (a_wstrb !== 4'b1100) begin miscompares++; $display("FAIL sh_wstrb got %h exp c", a_wstrb); end
        a_wrdy = 1'b1;
        step();
        a_idle();
        step();
    endtask

    task automatic test_misaligned();
        a_issue(1'b1, 3'b010, 5'd3, 32'h101, 32'h0, 12'h000);
        vectors++; if (a_wait !== 1'b0) begin miscompares++; $display("FAIL lw_mis_wait got %h exp 0", a_wait); end
        step();
        vectors++; if (a_exc !== 1'b1) begin miscompares++; $display("FAIL lw_mis_exc got %h exp 1", a_exc); end
        vectors++; if (a_cause !== 4'd4) begin miscompares++; $display("FAIL lw_mis_cause got %h exp 4", a_cause); end
        vectors++; if (a_tval !== 32'h101) begin miscompares++; $display("FAIL lw_mis_tval got %h exp 00000101", a_tval); end
        vectors++; if (a_ren !== 1'b0 || a_busy !== 1'b0) begin miscompares++; $display("FAIL lw_mis_idle got ren=%h busy=%h exp 0", a_ren, a_busy); end
        a_idle();
        step();
        vectors++; if (a_exc !== 1'b0) begin miscompares++; $display("FAIL lw_mis_pulse got %h exp 0", a_exc); end
        a_issue(1'b0, 3'b001, 5'd0, 32'h201, 32'h0, 12'h000);
        step();
        vectors++; if (a_cause !== 4'd6 || a_tval !== 32'h201) begin miscompares++; $display("FAIL sh_mis got cause=%h tval=%h exp 6/00000201", a_cause, a_tval); end
        a_idle();
        step();
    endtask

    task automatic test_illegal();
        a_issue(1'b0, 3'b011, 5'd0, 32'h100, 32'h0, 12'h000);
        step();
        vectors++; if (a_exc !== 1'b1 || a_cause !== 4'd2) begin miscompares++; $display("FAIL sd32 got exc=%h cause=%h exp 1/2", a_exc, a_cause); end
        vectors++; if (a_tval !== 32'h0 || a_wen !== 1'b0) begin miscompares++; $display("FAIL sd32_tval got tval=%h wen=%h exp 0/0", a_tval, a_wen); end
        a_idle();
        step();
        a_issue(1'b1, 3'b110, 5'd4, 32'h100, 32'h0, 12'h000);
        vectors++; if (a_wait !== 1'b0) begin miscompares++; $display("FAIL lwu32_wait got %h exp 0", a_wait); end
        step();
        vectors++; if (a_cause !== 4'd2 || a_ren !== 1'b0) begin miscompares++; $display("FAIL lwu32 got cause=%h ren=%h exp 2/0", a_cause, a_ren); end
        a_idle();
        step();
    endtask

    task automatic test_timeout();
        a_issue(1'b0, 3'b010, 5'd0, 32'h200, 32'hCAFE_BABE, 12'h004);
        step();
        vectors++; if (a_wdata !== 32'hCAFE_BABE || a_wstrb !== 4'hF) begin miscompares++; $display("FAIL sw_data got %h/%h exp cafebabe/f", a_wdata, a_wstrb); end
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++; if (a_wen !== 1'b1) begin miscompares++; $display("FAIL sw_wait%0d got %h exp 1", k, a_wen); end
        end
        step();
        vectors++; if (a_wen !== 1'b0 || a_exc !== 1'b1) begin miscompares++; $display("FAIL sw_to got wen=%h exc=%h exp 0/1", a_wen, a_exc); end
        vectors++; if (a_cause !== 4'd7 || a_tval !== 32'h204) begin miscompares++; $display("FAIL sw_to_cause got %h/%h exp 7/00000204", a_cause, a_tval); end
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL sw_to_busy got %h exp 0", a_busy); end
        a_idle();
        step();
        a_issue(1'b0, 3'b010, 5'd0, 32'h300, 32'h1, 12'h000);
        step();
        step(); step(); step();
        a_wrdy = 1'b1;
        step();
        vectors++; if (a_exc !== 1'b0 || a_wen !== 1'b0) begin miscompares++; $display("FAIL rdy_wins got exc=%h wen=%h exp 0/0", a_exc, a_wen); end
        a_idle();
        step();
    endtask

    task automatic test_rd_zero();
        a_issue(1'b1, 3'b010, 5'd0, 32'h300, 32'h0, 12'h000);
        step();
        a_din = 32'h1122_3344; a_rrdy = 1'b1;
        step();
        vectors++; if (a_rd_en !== 1'b0) begin miscompares++; $display("FAIL x0_rd_en got %h exp 0", a_rd_en); end
        a_idle();
        step();
    endtask

    task automatic test_reset_mid_read();
        a_issue(1'b1, 3'b010, 5'd9, 32'h400, 32'h0, 12'h000);
        step();
        vectors++; if (a_ren !== 1'b1) begin miscompares++; $display("FAIL mid_ren got %h exp 1", a_ren); end
        a_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        vectors++; if (a_ren !== 1'b0 || a_addr !== 32'h0 || a_rd_out !== 5'd0) begin miscompares++; $display("FAIL mid_rst got ren=%h addr=%h rd=%h exp 0", a_ren, a_addr, a_rd_out); end
        vectors++; if (a_rd_data !== 32'h0 || a_busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_data got %h busy=%h exp 0", a_rd_data, a_busy); end
        a_din = 32'h5555_5555; a_rrdy = 1'b1;
        step();
        rst = 1'b0;
        step();
        vectors++; if (a_rd_en !== 1'b0 || a_ren !== 1'b0) begin miscompares++; $display("FAIL mid_ready_ignored got rd_en=%h ren=%h exp 0", a_rd_en, a_ren); end
        vectors++; if (a_rd_data !== 32'h0) begin miscompares++; $display("FAIL mid_rd_data got %h exp 0", a_rd_data); end
        a_idle();
        step();
    endtask

    task automatic test_xlen64();
        b_issue(1'b1, 3'b011, 5'd10, 64'h1000, 64'h0, 12'h008);
        vectors++; if (b_wait !== 1'b1) begin miscompares++; $display("FAIL ld_wait got %h exp 1", b_wait); end
        step();
        vectors++; if (b_addr !== 64'h1008 || b_wstrb !== 8'h00) begin miscompares++; $display("FAIL ld_addr got %h/%h exp 1008/00", b_addr, b_wstrb); end
        repeat (10) step();
        vectors++; if (b_ren !== 1'b1 || b_exc !== 1'b0) begin miscompares++; $display("FAIL ld_no_to got ren=%h exc=%h exp 1/0", b_ren, b_exc); end
        b_din = 64'h8877_6655_4433_2211; b_rrdy = 1'b1;
        step();
        vectors++; if (b_rd_data !== 64'h8877_6655_4433_2211 || b_rd_en !== 1'b1) begin miscompares++; $display("FAIL ld_data got %h en=%h exp 8877665544332211/1", b_rd_data, b_rd_en); end
        b_idle();
        step();
        b_issue(1'b1, 3'b110, 5'd11, 64'h1000, 64'h0, 12'h004);
        step();
        b_din = 64'h8000_0001_0000_0000; b_rrdy = 1'b1;
        step();
        vectors++; if (b_rd_data !== 64'h0000_0000_8000_0001) begin miscompares++; $display("FAIL lwu_data got %h exp 0000000080000001", b_rd_data); end
        b_idle();
        step();
        b_issue(1'b1, 3'b010, 5'd12, 64'h1000, 64'h0, 12'h004);
        step();
        b_rrdy = 1'b1;
        step();
        vectors++; if (b_rd_data !== 64'hFFFF_FFFF_8000_0001) begin miscompares++; $display("FAIL lw64_data got %h exp ffffffff80000001", b_rd_data); end
        b_idle();
        step();
        b_issue(1'b0, 3'b010, 5'd0, 64'h1000, 64'h1122_3344_5566_7788, 12'h004);
        step();
        vectors++; if (b_wdata !== 64'h5566_7788_0000_0000 || b_wstrb !== 8'hF0) begin miscompares++; $display("FAIL sw64 got %h/%h exp 5566778800000000/f0", b_wdata, b_wstrb); end
        b_wrdy = 1'b1;
        step();
        b_idle();
        step();
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_load = 1'b0; a_funct3 = 3'b0; a_rd = 5'd0;
        a_rs1 = '0; a_rs2 = '0; a_imm = '0; a_din = '0; a_rrdy = 1'b0; a_wrdy = 1'b0;
        b_req_valid = 1'b0; b_req_load = 1'b0; b_funct3 = 3'b0; b_rd = 5'd0;
        b_rs1 = '0; b_rs2 = '0; b_imm = '0; b_din = '0; b_rrdy = 1'b0; b_wrdy = 1'b0;
        step();
        step();
        test_reset();
        test_lb();
        test_lhu();
        test_store_lanes();
        test_misaligned();
        test_illegal();
        test_timeout();
        test_rd_zero();
        test_reset_mid_read();
        test_xlen64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
